// File: rtl/mul_share_arbiter.sv
// -----------------------------------------------------------------------------
// mul_share_arbiter
//
// Shares one external fixed-latency multiplier among NREQ requesters.
// A round-robin arbiter picks one requester per cycle. Its operands go to the
// multiplier as a registered issue. A tag pipeline follows each issue's
// requester ID until the product comes back. Products and IDs are stored in a
// FIFO with a registered head.
//
// A credit counter (occ) counts every result that has been issued and not yet
// popped. Issue is allowed only while a credit is free. This is why the
// multiplier, which cannot be stalled, can never overflow the FIFO.
//
// Optional feature (macro MUL_SHARE_ARB_HIPRIO_EN):
//   defined   - requester 0 wins whenever it is valid, and its grants leave the
//               pointer where it is. Requesters 1..NREQ-1 round-robin.
//   undefined - plain round-robin over all NREQ requesters.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready   per-requester handshake; req_ready is one-hot or zero
//   req_a/req_b           packed operands, requester i at [i*OP_W +: OP_W]
//   mul_en/mul_a/mul_b    registered operand issue to the multiplier
//   mul_res               product, valid MUL_LAT cycles after mul_en
//   rsp_valid/rsp_ready   result FIFO head handshake
//   rsp_data/rsp_id       product and originating requester
//   busy                  at least one result is issued and not yet popped
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module mul_share_arbiter #(
    parameter int NREQ       = 4,
    parameter int OP_W       = 10,
    parameter int RES_W      = 21,
    parameter int MUL_LAT    = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*OP_W-1:0]    req_a,
    input  logic [NREQ*OP_W-1:0]    req_b,
    output logic                    mul_en,
    output logic [OP_W-1:0]         mul_a,
    output logic [OP_W-1:0]         mul_b,
    input  logic [RES_W-1:0]        mul_res,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [RES_W-1:0]        rsp_data,
    output logic [$clog2(NREQ)-1:0] rsp_id,
    output logic                    busy
);

    localparam int ID_W  = $clog2(NREQ);
    localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int ENT_W = ID_W + RES_W;

    localparam logic [ID_W:0]    NREQ_C    = (ID_W+1)'(NREQ);
    localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(NREQ - 1);
    localparam logic [OCC_W-1:0] OCC_FULL  = OCC_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] LAST_SLOT = PTR_W'(FIFO_DEPTH - 1);

`ifdef MUL_SHARE_ARB_HIPRIO_EN
    localparam logic HIPRIO = 1'b1;
`else
    localparam logic HIPRIO = 1'b0;
`endif

    // Advance a FIFO slot pointer with wrap at FIFO_DEPTH.
    function automatic logic [PTR_W-1:0] slot_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_SLOT) ? PTR_W'(1'b0) : p + PTR_W'(1'b1);
    endfunction

    // Arbitration and issue
    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic             grant_found_s;
    logic [ID_W-1:0]  grant_id_s;
    logic             allow_s, hs_s, pop_s;
    logic             mul_en_q;
    logic [OP_W-1:0]  mul_a_q, mul_b_q;
    logic [ID_W-1:0]  iss_id_q;

    // Tag pipeline
    logic             tag_vld_q [MUL_LAT];
    logic [ID_W-1:0]  tag_id_q  [MUL_LAT];

    // Credits
    logic [OCC_W-1:0] occ_q, occ_d;
    logic             busy_q;

    // Result FIFO
    logic [ENT_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [OCC_W-1:0] cnt_q, cnt_d, cnt_left_s;
    logic             wr_en_s;
    logic [ENT_W-1:0] wr_ent_s;
    logic             rsp_valid_q, rsp_valid_d;
    logic [ENT_W-1:0] head_q, head_d;

    // Pop is based only on registered state, so it can free a credit for
    // an issue in the same cycle without forming a combinational loop.
    assign pop_s   = rsp_valid_q && rsp_ready;
    assign allow_s = (occ_q < OCC_FULL) || pop_s;
    assign hs_s    = allow_s && grant_found_s;

    // Round-robin search from ptr upward, plus optional requester-0 override.
    always_comb begin
        logic [ID_W:0] cand_v;
        cand_v        = {(ID_W+1){1'b0}};
        grant_found_s = 1'b0;
        grant_id_s    = {ID_W{1'b0}};
        for (int k = 0; k < NREQ; k++) begin
            cand_v = {1'b0, ptr_q} + (ID_W+1)'(k);
            if (cand_v >= NREQ_C) begin
                cand_v = cand_v - NREQ_C;
            end else begin
                cand_v = cand_v;
            end
            if (!grant_found_s && req_valid[cand_v[ID_W-1:0]] &&
                !(HIPRIO && (cand_v == {(ID_W+1){1'b0}}))) begin
                grant_found_s = 1'b1;
                grant_id_s    = cand_v[ID_W-1:0];
            end else begin
                grant_found_s = grant_found_s;
            end
        end
        if (HIPRIO && req_valid[0]) begin
            grant_found_s = 1'b1;
            grant_id_s    = {ID_W{1'b0}};
        end else begin
            grant_id_s    = grant_id_s;
        end
    end

    // One-hot ready toward the granted requester, only when issue is allowed.
    always_comb begin
        req_ready = {NREQ{1'b0}};
        if (hs_s) begin
            req_ready[grant_id_s] = 1'b1;
        end else begin
            req_ready = {NREQ{1'b0}};
        end
    end

    // Next pointer: one past the winner. A high-priority requester-0 grant
    // does not move it.
    always_comb begin
        ptr_d = ptr_q;
        if (hs_s && !(HIPRIO && (grant_id_s == {ID_W{1'b0}}))) begin
            ptr_d = (grant_id_s == LAST_ID) ? {ID_W{1'b0}} : grant_id_s + ID_W'(1'b1);
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Pointer and registered operand issue; operands hold when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q    <= {ID_W{1'b0}};
            mul_en_q <= 1'b0;
            mul_a_q  <= {OP_W{1'b0}};
            mul_b_q  <= {OP_W{1'b0}};
            iss_id_q <= {ID_W{1'b0}};
        end else begin
            ptr_q    <= ptr_d;
            mul_en_q <= hs_s;
            if (hs_s) begin
                mul_a_q  <= req_a[grant_id_s*OP_W +: OP_W];
                mul_b_q  <= req_b[grant_id_s*OP_W +: OP_W];
                iss_id_q <= grant_id_s;
            end
        end
    end

    // Tag pipeline aligned so the last stage coincides with the matching mul_res.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < MUL_LAT; k++) begin
                tag_vld_q[k] <= 1'b0;
                tag_id_q[k]  <= {ID_W{1'b0}};
            end
        end else begin
            tag_vld_q[0] <= mul_en_q;
            tag_id_q[0]  <= iss_id_q;
            for (int k = 1; k < MUL_LAT; k++) begin
                tag_vld_q[k] <= tag_vld_q[k-1];
                tag_id_q[k]  <= tag_id_q[k-1];
            end
        end
    end

    // Credit counter: a result issued and popped in the same cycle leaves occ unchanged.
    always_comb begin
        case ({hs_s, pop_s})
            2'b10:   occ_d = occ_q + OCC_W'(1'b1);
            2'b01:   occ_d = occ_q - OCC_W'(1'b1);
            default: occ_d = occ_q;
        endcase
    end

    // Credit counter and busy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q  <= {OCC_W{1'b0}};
            busy_q <= 1'b0;
        end else begin
            occ_q  <= occ_d;
            busy_q <= (occ_d != {OCC_W{1'b0}});
        end
    end

    assign wr_en_s  = tag_vld_q[MUL_LAT-1];
    assign wr_ent_s = {tag_id_q[MUL_LAT-1], mul_res};

    // FIFO bookkeeping and next head. If a write lands in a FIFO that is empty
    // after this cycle's pop, the write bypasses straight into the head.
    always_comb begin
        cnt_left_s = pop_s ? (cnt_q - OCC_W'(1'b1)) : cnt_q;
        cnt_d      = wr_en_s ? (cnt_left_s + OCC_W'(1'b1)) : cnt_left_s;
        rd_ptr_d   = pop_s ? slot_inc(rd_ptr_q) : rd_ptr_q;
        wr_ptr_d   = wr_en_s ? slot_inc(wr_ptr_q) : wr_ptr_q;
        if (cnt_d == {OCC_W{1'b0}}) begin
            rsp_valid_d = 1'b0;
            head_d      = head_q;
        end else if (cnt_left_s == {OCC_W{1'b0}}) begin
            rsp_valid_d = 1'b1;
            head_d      = wr_ent_s;
        end else begin
            rsp_valid_d = 1'b1;
            head_d      = mem_q[rd_ptr_d];
        end
    end

    // FIFO storage: contents are qualified by cnt_q, so no reset is needed.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_q[wr_ptr_q] <= wr_ent_s;
        end
    end

    // FIFO pointers, count and registered head.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q    <= {PTR_W{1'b0}};
            wr_ptr_q    <= {PTR_W{1'b0}};
            cnt_q       <= {OCC_W{1'b0}};
            rsp_valid_q <= 1'b0;
            head_q      <= {ENT_W{1'b0}};
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            head_q      <= head_d;
        end
    end

    assign mul_en    = mul_en_q;
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = head_q[RES_W-1:0];
    assign rsp_id    = head_q[ENT_W-1:RES_W];
    assign busy      = busy_q;

endmodule
